cachepool_boot_ctrl: RTL
========================

// Module: cachepool_boot_ctrl
// PURPOSE
//  Testbench-side boot sequencer driving the reqrsp port of the reqrsp_to_axi bridge into the cluster's AXI slave.
//  Sequence: latch ELF entry point, wait a programmable delay, write the entry point to the cluster boot-control register,
//  take the write response, then pulse debug_req to wake all cores. Replaces the ad-hoc boot sequence in the harness.
// PARAMETERS
//  NumCores      cachepool_pkg::NumCores  width of debug_req_o
//  StartDelay    1000   cycles from entry latch to boot write; 0 = write on next cycle
//  WakeCycles    1      debug_req_o high duration in cycles (>=1)
//  BootAddr      PeriStartAddr+SPATZ_CLUSTER_PERIPHERAL_CLUSTER_BOOT_CONTROL_OFFSET  boot register address
//  EocAddr       PeriStartAddr+32'h0    end-of-computation register (used only with CACHEPOOL_BOOT_EOC_POLL_EN)
//  PollInterval  256    idle cycles between EOC polls (>=1)
//  reqrsp_req_t / reqrsp_rsp_t  reqrsp_cluster_in types (32b data, 4b strb)
// PORTS
//  clk_i          in   1         clock
//  rst_ni         in   1         async reset, active low
//  entry_point_i  in   32        boot PC, sampled when entry_valid_i & state==IDLE
//  entry_valid_i  in   1         single-cycle start strobe
//  reqrsp_req_o   out  req_t     to reqrsp_to_axi
//  reqrsp_rsp_i   in   rsp_t     from reqrsp_to_axi
//  debug_req_o    out  NumCores  wake pulse to all cores
//  boot_done_o    out  1         sticky; cores woken
//  err_o          out  1         sticky; boot write returned p.error
//  eoc_o          out  1         sticky; EOC seen (tied 0 without macro)
//  exit_code_o    out  31        EOC value >>1 (tied 0 without macro)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Async assert mid-sequence aborts immediately; no request retained.
//  FSM: IDLE -(entry_valid_i)-> DELAY -(cnt==StartDelay-1, or StartDelay==0)-> REQ -(q_valid&q_ready)-> RSP
//       RSP -(p_valid, !p.error)-> WAKE; RSP -(p_valid, p.error)-> ERR (err_o=1, terminal, no wake)
//       WAKE -(WakeCycles elapsed)-> DONE (terminal without macro).
//  entry_valid_i outside IDLE ignored; entry point held in register, never re-sampled.
//  REQ: q_valid=1, q.addr=BootAddr, q.data=entry, write=1, strb='1, amo=AMONone, other fields 0;
//       all q fields stable while q_valid & !q_ready (no valid drop before handshake).
//  RSP: p_ready=1 for whole state; q_valid=0. p_ready=0 in every other state.
//  WAKE: debug_req_o='1 for exactly WakeCycles cycles, registered; first high cycle is the one after p handshake.
//  boot_done_o rises in the cycle WAKE exits; stays until reset.
//  Delay counter width $clog2(StartDelay+1), saturating compare, no wrap.
//  Zero-cycle paths: q_ready same cycle as q_valid -> RSP next cycle; p_valid in first RSP cycle accepted.
// CONFIGURATION
//  CACHEPOOL_BOOT_EOC_POLL_EN defined: DONE -> POLL_WAIT (PollInterval cycles) -> POLL_REQ (read EocAddr,
//   write=0, strb='1) -> POLL_RSP; if p.data[0]==1: eoc_o=1, exit_code_o=p.data[31:1], state EOC (terminal);
//   else back to POLL_WAIT. p.error during poll -> err_o=1, keep polling.
//  Undefined: no poll states, no EocAddr/PollInterval logic, eoc_o=0, exit_code_o=0.
// STRUCTURE
//  cachepool_pkg: boot_state_e enum, BootStartDelay/BootWakeCycles/BootPollInterval defaults, EOC register offset.
//  One sub-module: cachepool_boot_reqrsp_master (one-shot reqrsp transaction: start, addr, data, write ->
//  done, rdata, error); top FSM instantiates it once for boot write and EOC reads.
// TESTING
//  1 entry=0x8000_0000, StartDelay=10, q_ready same cycle, p_valid 2 cycles later -> write at cycle 11 after strobe,
//    addr=BootAddr, data=0x8000_0000; debug_req_o='1 one cycle; boot_done_o=1.
//  2 q_ready held low 5 cycles with random field checker -> q_valid and q fields constant all 5 cycles, one write only.
//  3 p.error=1 on boot response -> err_o=1, debug_req_o never asserted, boot_done_o=0, no further requests.
//  4 rst_ni low in RSP state, release, new strobe entry=0x8000_1000 -> outputs 0 during reset, clean second boot
//    with new data; second entry_valid_i pulse during DELAY ignored.
//  5 StartDelay=0, WakeCycles=3 -> q_valid cycle after strobe; debug_req_o high exactly 3 cycles.
//  6 (macro on) EOC reads return 0 twice then 0x0000_0015 -> 3 reads spaced PollInterval, eoc_o=1, exit_code_o=10.

Source files
------------

// File: rtl/cachepool_pkg.sv
// Shared types and defaults for the cachepool boot controller and its reqrsp master.
// The EOC poll states only exist when CACHEPOOL_BOOT_EOC_POLL_EN is defined.
package cachepool_pkg;

   localparam int unsigned NumCores = 4;
   localparam logic [31:0] PeriStartAddr = 32'h1000_0000;
   localparam logic [31:0] SpatzClusterPeripheralClusterBootControlOffset = 32'h0000_0058;
   localparam logic [31:0] EocRegOffset = 32'h0000_0000;

   localparam int unsigned BootStartDelay   = 1000;
   localparam int unsigned BootWakeCycles   = 1;
   localparam int unsigned BootPollInterval = 256;

   typedef enum logic [3:0] {
      AMONone = 4'h0,
      AMOSwap = 4'h1,
      AMOAdd  = 4'h2,
      AMOAnd  = 4'h3,
      AMOOr   = 4'h4,
      AMOXor  = 4'h5
   } amo_op_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      amo_op_e     amo;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [2:0]  size;
   } reqrsp_req_chan_t;

   typedef struct packed {
      reqrsp_req_chan_t q;
      logic             q_valid;
      logic             p_ready;
   } reqrsp_req_t;

   typedef struct packed {
      logic [31:0] data;
      logic        error;
   } reqrsp_rsp_chan_t;

   typedef struct packed {
      reqrsp_rsp_chan_t p;
      logic             p_valid;
      logic             q_ready;
   } reqrsp_rsp_t;

   typedef enum logic [3:0] {
      BootIdle,
      BootDelay,
      BootReq,
      BootRsp,
      BootWake,
      BootErr,
      BootDone
`ifdef CACHEPOOL_BOOT_EOC_POLL_EN
      ,
      BootPollWait,
      BootPollReq,
      BootPollRsp,
      BootEoc
`endif
   } boot_state_e;

endpackage

// File: rtl/cachepool_boot_reqrsp_master.sv
// One-shot reqrsp master: start latches addr/data/write, drives q until accepted,
// then accepts a single p beat and pulses done with the response data/error.
module cachepool_boot_reqrsp_master
   import cachepool_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic        write_i,
   output reqrsp_req_t req_o,
   input  reqrsp_rsp_t rsp_i,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        error_o
);

   typedef enum logic [1:0] {MstIdle, MstReq, MstRsp} mst_state_e;

   mst_state_e  st_q, st_d;
   logic [31:0] addr_q, data_q;
   logic        write_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st_q    <= MstIdle;
         addr_q  <= '0;
         data_q  <= '0;
         write_q <= 1'b0;
      end else begin
         st_q <= st_d;
         if (st_q == MstIdle && start_i) begin
            addr_q  <= addr_i;
            data_q  <= data_i;
            write_q <= write_i;
         end
      end
   end

   // q fields come straight from registers, so they cannot move while stalled
   always_comb begin
      st_d   = st_q;
      req_o  = '0;
      done_o = 1'b0;
      case (st_q)
         MstIdle: if (start_i) st_d = MstReq;
         MstReq: begin
            req_o.q_valid = 1'b1;
            req_o.q.addr  = addr_q;
            req_o.q.data  = data_q;
            req_o.q.write = write_q;
            req_o.q.strb  = '1;
            req_o.q.amo   = AMONone;
            if (rsp_i.q_ready) st_d = MstRsp;
         end
         MstRsp: begin
            req_o.p_ready = 1'b1;
            if (rsp_i.p_valid) begin
               done_o = 1'b1;
               st_d   = MstIdle;
            end
         end
         default: st_d = MstIdle;
      endcase
   end

   assign rdata_o = rsp_i.p.data;
   assign error_o = rsp_i.p.error;

endmodule

// File: rtl/cachepool_boot_ctrl.sv
// Boot sequencer: latch entry, wait, write boot register, wake cores.
// CACHEPOOL_BOOT_EOC_POLL_EN adds polling of the EOC register after wake-up.
module cachepool_boot_ctrl
   import cachepool_pkg::*;
#(
   parameter int unsigned NumCores     = cachepool_pkg::NumCores,
   parameter int unsigned StartDelay   = BootStartDelay,
   parameter int unsigned WakeCycles   = BootWakeCycles,
   parameter logic [31:0] BootAddr     = PeriStartAddr + SpatzClusterPeripheralClusterBootControlOffset,
   parameter logic [31:0] EocAddr      = PeriStartAddr + EocRegOffset,
   parameter int unsigned PollInterval = BootPollInterval
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [31:0]         entry_point_i,
   input  logic                entry_valid_i,
   output reqrsp_req_t         reqrsp_req_o,
   input  reqrsp_rsp_t         reqrsp_rsp_i,
   output logic [NumCores-1:0] debug_req_o,
   output logic                boot_done_o,
   output logic                err_o,
   output logic                eoc_o,
   output logic [30:0]         exit_code_o
);

   localparam int unsigned DlyW  = (StartDelay > 0) ? $clog2(StartDelay + 1) : 1;
   localparam int unsigned WakeW = $clog2(WakeCycles + 1);
   localparam logic [DlyW-1:0]  DlyLast  = DlyW'((StartDelay > 0) ? StartDelay - 1 : 0);
   localparam logic [WakeW-1:0] WakeLast = WakeW'(WakeCycles - 1);

   boot_state_e      state_q, state_d;
   logic [DlyW-1:0]  dly_q;
   logic [WakeW-1:0] wake_q;
   logic [31:0]      entry_q;
   logic             dbg_q, boot_done_q, err_q, err_set;
   logic             start, m_write, m_done, m_error, q_hs;
   logic [31:0]      m_addr, m_data, m_rdata;

   cachepool_boot_reqrsp_master u_master (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (start),
      .addr_i  (m_addr),
      .data_i  (m_data),
      .write_i (m_write),
      .req_o   (reqrsp_req_o),
      .rsp_i   (reqrsp_rsp_i),
      .done_o  (m_done),
      .rdata_o (m_rdata),
      .error_o (m_error)
   );

   assign q_hs = reqrsp_req_o.q_valid & reqrsp_rsp_i.q_ready;

`ifdef CACHEPOOL_BOOT_EOC_POLL_EN
   localparam int unsigned PollW = $clog2(PollInterval + 1);
   localparam logic [PollW-1:0] PollLast = PollW'(PollInterval - 1);
   logic [PollW-1:0] poll_q;
   logic             eoc_q, eoc_set;
   logic [30:0]      exit_q;
`endif

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      m_addr  = BootAddr;
      m_data  = entry_q;
      m_write = 1'b1;
      err_set = 1'b0;
`ifdef CACHEPOOL_BOOT_EOC_POLL_EN
      eoc_set = 1'b0;
`endif
      case (state_q)
         BootIdle: begin
            // a zero delay launches the write straight from the strobe
            m_data = entry_point_i;
            if (entry_valid_i) begin
               start   = (StartDelay == 0);
               state_d = (StartDelay == 0) ? BootReq : BootDelay;
            end
         end
         BootDelay: if (dly_q >= DlyLast) begin
            start   = 1'b1;
            state_d = BootReq;
         end
         BootReq: if (q_hs) state_d = BootRsp;
         BootRsp: if (m_done) begin
            err_set = m_error;
            state_d = m_error ? BootErr : BootWake;
         end
         BootWake: if (wake_q >= WakeLast) state_d = BootDone;
         BootErr:  state_d = BootErr;
`ifdef CACHEPOOL_BOOT_EOC_POLL_EN
         BootDone: state_d = BootPollWait;
         BootPollWait: begin
            m_addr  = EocAddr;
            m_data  = '0;
            m_write = 1'b0;
            if (poll_q >= PollLast) begin
               start   = 1'b1;
               state_d = BootPollReq;
            end
         end
         BootPollReq: if (q_hs) state_d = BootPollRsp;
         BootPollRsp: if (m_done) begin
            if (m_error) begin
               err_set = 1'b1;
               state_d = BootPollWait;
            end else if (m_rdata[0]) begin
               eoc_set = 1'b1;
               state_d = BootEoc;
            end else begin
               state_d = BootPollWait;
            end
         end
         BootEoc: state_d = BootEoc;
`else
         BootDone: state_d = BootDone;
`endif
         default: state_d = BootIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= BootIdle;
         dly_q       <= '0;
         wake_q      <= '0;
         entry_q     <= '0;
         dbg_q       <= 1'b0;
         boot_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == BootIdle && entry_valid_i) entry_q <= entry_point_i;
         if (state_q != BootDelay)  dly_q <= '0;
         else if (dly_q < DlyLast)  dly_q <= dly_q + 1'b1;
         if (state_q != BootWake)   wake_q <= '0;
         else if (wake_q < WakeLast) wake_q <= wake_q + 1'b1;
         dbg_q       <= (state_d == BootWake);
         boot_done_q <= boot_done_q | (state_q == BootWake && state_d == BootDone);
         err_q       <= err_q | err_set;
      end
   end

   assign debug_req_o = {NumCores{dbg_q}};
   assign boot_done_o = boot_done_q;
   assign err_o       = err_q;

`ifdef CACHEPOOL_BOOT_EOC_POLL_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         poll_q <= '0;
         eoc_q  <= 1'b0;
         exit_q <= '0;
      end else begin
         if (state_q != BootPollWait) poll_q <= '0;
         else if (poll_q < PollLast)  poll_q <= poll_q + 1'b1;
         if (eoc_set) begin
            eoc_q  <= 1'b1;
            exit_q <= m_rdata[31:1];
         end
      end
   end

   assign eoc_o       = eoc_q;
   assign exit_code_o = exit_q;
`else
   logic unused_poll;
   assign unused_poll = ^{m_rdata, EocAddr, PollInterval};
   assign eoc_o       = 1'b0;
   assign exit_code_o = '0;
`endif

endmodule
